// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter feeding a single-port memory: one command per cycle, reads return 2 cycles after grant.
// Define MEMARB_CNT_EN to add saturating per-port grant counters (a_gnt_cnt, b_gnt_cnt).
module mem_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_ADDR   = 16,
   parameter int ADDRSIZE   = $clog2(MAX_ADDR)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDRSIZE-1:0]   a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDRSIZE-1:0]   b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  mem_rd_en,
   output logic                  mem_wr_en,
   output logic [ADDRSIZE-1:0]   mem_rd_addr,
   output logic [ADDRSIZE-1:0]   mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
`ifdef MEMARB_CNT_EN
   output logic [15:0]           a_gnt_cnt,
   output logic [15:0]           b_gnt_cnt,
`endif
   output logic                  dbg_pri
);

   // Handshake: a request is held with x_req=1 until x_gnt=1 in the same cycle; that cycle transfers the command.
   typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_e;

   pri_e                  pri_q, pri_d;
   logic                  rd_en_q, rd_en_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDRSIZE-1:0]   rd_addr_q, rd_addr_d;
   logic [ADDRSIZE-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  tag_b_q, tag_b_d;
   logic                  ret_a_q, ret_a_d;
   logic                  ret_b_q, ret_b_d;
   logic                  sel_we;
   logic [ADDRSIZE-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // Grants are masked while reset is asserted so no output toggles during reset.
   assign a_gnt = rst_n & a_req & (~b_req | (pri_q == PRI_A));
   assign b_gnt = rst_n & b_req & (~a_req | (pri_q == PRI_B));

   always_comb begin
      pri_d     = pri_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      sel_we    = b_gnt ? b_we    : a_we;
      sel_addr  = b_gnt ? b_addr  : a_addr;
      sel_wdata = b_gnt ? b_wdata : a_wdata;
      if (a_gnt)      pri_d = PRI_B;
      else if (b_gnt) pri_d = PRI_A;
      rd_en_d = (a_gnt | b_gnt) & ~sel_we;
      wr_en_d = (a_gnt | b_gnt) & sel_we;
      if (rd_en_d) rd_addr_d = sel_addr;
      if (wr_en_d) begin
         wr_addr_d = sel_addr;
         wr_data_d = sel_wdata;
      end
      tag_b_d = b_gnt;
      ret_a_d = rd_en_q & ~tag_b_q;
      ret_b_d = rd_en_q & tag_b_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pri_q     <= PRI_A;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         tag_b_q   <= 1'b0;
         ret_a_q   <= 1'b0;
         ret_b_q   <= 1'b0;
      end else begin
         pri_q     <= pri_d;
         rd_en_q   <= rd_en_d;
         wr_en_q   <= wr_en_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         tag_b_q   <= tag_b_d;
         ret_a_q   <= ret_a_d;
         ret_b_q   <= ret_b_d;
      end
   end

   assign mem_rd_en   = rd_en_q;
   assign mem_wr_en   = wr_en_q;
   assign mem_rd_addr = rd_addr_q;
   assign mem_wr_addr = wr_addr_q;
   assign mem_wr_data = wr_data_q;
   assign a_rvalid    = ret_a_q;
   assign b_rvalid    = ret_b_q;
   assign a_rdata     = ret_a_q ? mem_rd_data : '0;
   assign b_rdata     = ret_b_q ? mem_rd_data : '0;
   assign dbg_pri     = pri_q;

`ifdef MEMARB_CNT_EN
   logic [15:0] a_cnt_q, a_cnt_d;
   logic [15:0] b_cnt_q, b_cnt_d;

   always_comb begin
      a_cnt_d = a_cnt_q;
      b_cnt_d = b_cnt_q;
      if (a_gnt && (a_cnt_q != 16'hFFFF)) a_cnt_d = a_cnt_q + 16'd1;
      if (b_gnt && (b_cnt_q != 16'hFFFF)) b_cnt_d = b_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_cnt_q <= '0;
         b_cnt_q <= '0;
      end else begin
         a_cnt_q <= a_cnt_d;
         b_cnt_q <= b_cnt_d;
      end
   end

   assign a_gnt_cnt = a_cnt_q;
   assign b_gnt_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory (read wins over write).
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_req, a_we, b_req, b_we;
   logic [3:0] a_addr, b_addr;
   logic [7:0] a_wdata, b_wdata;
   logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [7:0] a_rdata, b_rdata;
   logic       mem_rd_en, mem_wr_en;
   logic [3:0] mem_rd_addr, mem_wr_addr;
   logic [7:0] mem_wr_data;
   logic [7:0] mem_rd_data = 8'h00;
   logic       dbg_pri;
`ifdef MEMARB_CNT_EN
   logic [15:0] a_gnt_cnt, b_gnt_cnt;
`endif

   logic [7:0] mem [16];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
`ifdef MEMARB_CNT_EN
      .a_gnt_cnt(a_gnt_cnt), .b_gnt_cnt(b_gnt_cnt),
`endif
      .dbg_pri(dbg_pri)
   );

   // Memory model: read has priority and drops a simultaneous write.
   always @(posedge clk) begin
      if (mem_rd_en)      mem_rd_data <= mem[mem_rd_addr];
      else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the settle point of the next cycle: inputs change at +2, checks at +3 after posedge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      bit exp_ag, exp_bg;
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
      rst_n = 1'b0; a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
      a_addr = 4'd1; b_addr = 4'd2; a_wdata = 8'h00; b_wdata = 8'h00;

      // Reset with both requests held
      cyc(); cyc(); #1;
      chk("rst_a_gnt", 16'(a_gnt), 16'd0);
      chk("rst_b_gnt", 16'(b_gnt), 16'd0);
      chk("rst_rd_en", 16'(mem_rd_en), 16'd0);
      chk("rst_wr_en", 16'(mem_wr_en), 16'd0);
      chk("rst_rvalid", 16'({a_rvalid, b_rvalid}), 16'd0);
      chk("rst_addr", 16'({mem_rd_addr, mem_wr_addr}), 16'd0);
      chk("rst_pri", 16'(dbg_pri), 16'd0);

      cyc(); rst_n = 1'b1; #1;
      chk("t1_first_gnt", 16'({a_gnt, b_gnt}), 16'b10);
      cyc(); a_req = 1'b0; #1;
      chk("t1_b_lone_gnt", 16'(b_gnt), 16'd1);
      chk("t1_rd_en", 16'(mem_rd_en), 16'd1);
      chk("t1_rd_addr", 16'(mem_rd_addr), 16'd1);
      chk("t1_pri_b", 16'(dbg_pri), 16'd1);
      cyc(); b_req = 1'b0; #1;
      chk("t1_a_rvalid", 16'({a_rvalid, b_rvalid}), 16'b10);
      chk("t1_a_rdata", 16'(a_rdata), 16'h11);
      chk("t1_rd_addr_b", 16'(mem_rd_addr), 16'd2);
      chk("t1_pri_a", 16'(dbg_pri), 16'd0);
      cyc(); #1;
      chk("t1_b_rvalid", 16'({a_rvalid, b_rvalid}), 16'b01);
      chk("t1_b_rdata", 16'(b_rdata), 16'h12);
      chk("t1_idle_rd_en", 16'(mem_rd_en), 16'd0);
      chk("t1_idle_addr_hold", 16'(mem_rd_addr), 16'd2);

      // A writes 5A @3 then reads @3
      cyc(); a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 8'h5A; #1;
      chk("t2_wr_gnt", 16'(a_gnt), 16'd1);
      cyc(); a_we = 1'b0; #1;
      chk("t2_rd_gnt", 16'(a_gnt), 16'd1);
      chk("t2_wr_en", 16'({mem_wr_en, mem_rd_en}), 16'b10);
      chk("t2_wr_addr", 16'(mem_wr_addr), 16'd3);
      chk("t2_wr_data", 16'(mem_wr_data), 16'h5A);
      cyc(); a_req = 1'b0; #1;
      chk("t2_rd_en", 16'({mem_wr_en, mem_rd_en}), 16'b01);
      chk("t2_rd_addr", 16'(mem_rd_addr), 16'd3);
      cyc(); #1;
      chk("t2_rvalid", 16'({a_rvalid, b_rvalid}), 16'b10);
      chk("t2_rdata", 16'(a_rdata), 16'h5A);

      // Both read continuously; pointer is PRI_B here so B goes first
      a_addr = 4'd4; b_addr = 4'd5;
      for (int i = 0; i < 8; i++) begin
         cyc();
         a_req = (i < 6); b_req = (i < 6);
         #1;
         exp_bg = (i < 6) && (i % 2 == 0);
         exp_ag = (i < 6) && (i % 2 == 1);
         chk($sformatf("t3_gnt_%0d", i), 16'({a_gnt, b_gnt}), 16'({exp_ag, exp_bg}));
         chk($sformatf("t3_excl_%0d", i), 16'(mem_rd_en & mem_wr_en), 16'd0);
         if (i >= 2) begin
            chk($sformatf("t3_rv_%0d", i), 16'({a_rvalid, b_rvalid}),
                16'({(i - 2) % 2 == 1 && i < 8, (i - 2) % 2 == 0 && i < 8}));
            if (a_rvalid) chk($sformatf("t3_ad_%0d", i), 16'(a_rdata), 16'h14);
            if (b_rvalid) chk($sformatf("t3_bd_%0d", i), 16'(b_rdata), 16'h15);
         end
      end

      // B writes C3 @7, A reads @7 next cycle
      cyc(); b_req = 1'b1; b_we = 1'b1; b_addr = 4'd7; b_wdata = 8'hC3; #1;
      chk("t4_b_wr_gnt", 16'(b_gnt), 16'd1);
      cyc(); b_req = 1'b0; b_we = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 4'd7; #1;
      chk("t4_a_rd_gnt", 16'(a_gnt), 16'd1);
      chk("t4_wr_data", 16'(mem_wr_data), 16'hC3);
      cyc(); a_req = 1'b0; #1;
      chk("t4_rd_en", 16'(mem_rd_en), 16'd1);
      cyc(); #1;
      chk("t4_rvalid", 16'(a_rvalid), 16'd1);
      chk("t4_rdata", 16'(a_rdata), 16'hC3);
      chk("t4_pri", 16'(dbg_pri), 16'd1);

      // Reset while a read is in flight
      cyc(); a_req = 1'b1; a_addr = 4'd3; #1;
      chk("t5_gnt", 16'(a_gnt), 16'd1);
      cyc(); a_req = 1'b0; rst_n = 1'b0; #1;
      chk("t5_rd_en_cleared", 16'(mem_rd_en), 16'd0);
      cyc(); rst_n = 1'b1; #1;
      chk("t5_no_rvalid0", 16'(a_rvalid), 16'd0);
      cyc(); #1;
      chk("t5_no_rvalid1", 16'(a_rvalid), 16'd0);
      chk("t5_pri", 16'(dbg_pri), 16'd0);
      cyc(); a_req = 1'b1; b_req = 1'b1; #1;
      chk("t5_a_wins", 16'({a_gnt, b_gnt}), 16'b10);
      cyc(); a_req = 1'b0; b_req = 1'b0; #1;

`ifdef MEMARB_CNT_EN
      cyc(); rst_n = 1'b0; #1;
      chk("t6_cnt_rst", 16'(a_gnt_cnt | b_gnt_cnt), 16'd0);
      cyc(); rst_n = 1'b1;
      a_req = 1'b1;
      for (int i = 0; i < 10; i++) cyc();
      a_req = 1'b0; b_req = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      b_req = 1'b0; #1;
      chk("t6_a_cnt", a_gnt_cnt, 16'd10);
      chk("t6_b_cnt", b_gnt_cnt, 16'd4);
      cyc(); a_req = 1'b1;
      for (int i = 0; i < 65525; i++) cyc();
      #1;
      chk("t6_a_full", a_gnt_cnt, 16'hFFFF);
      cyc(); a_req = 1'b0; #1;
      chk("t6_a_sat", a_gnt_cnt, 16'hFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
